gcd_binary_unit: RTL and testbench

- Parametrised successor to the existing 16-bit GCD black box. Computes gcd(a,b) with the binary (Stein) algorithm: shifts and subtracts only, no divider.
- Width is configurable.
- Adds output-side backpressure (valid/ready on both sides), defined zero-operand handling, and a busy flag.
- Sits as a memory-mapped accelerator leaf behind the console peripheral wrapper.

---
 rtl/gcd_binary_unit.sv | 133 +++++++++++++
 tb/tb_gcd_binary_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_binary_unit.sv
// -----------------------------------------------------------------------------
// gcd_binary_unit
//
// Binary (Stein) GCD engine. It uses shifts and subtractions only, with no
// divider. Operands are accepted through a valid/ready handshake on the input
// side. The result is offered through a valid/ready handshake on the output
// side. The unit processes one operation at a time: IDLE -> CALC -> DONE.
//
// Optional feature: define GCD_CYCLE_COUNT_EN to add o_cycles. It reports the
// number of CALC cycles (including the terminating one) taken by the current
// or last result.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_a, i_b     operands, sampled on input handshake
//   i_in_valid   operands valid
//   o_in_ready   unit can accept operands (state == IDLE)
//   o_out_valid  o_c holds a result (state == DONE)
//   i_out_ready  consumer accepts result
//   o_c          gcd result, held until the next result is produced
//   o_busy       high while computing (state == CALC)
//   o_cycles     (GCD_CYCLE_COUNT_EN only) CALC cycle count of the result
// -----------------------------------------------------------------------------
module gcd_binary_unit #(
  parameter  int WIDTH = 16,
  localparam int K_W   = $clog2(WIDTH + 1),
  localparam int CNT_W = $clog2(2 * WIDTH + 2)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_c,
`ifdef GCD_CYCLE_COUNT_EN
  output logic [CNT_W-1:0] o_cycles,
`endif
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [K_W-1:0]   k;    // common power of two removed so far
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt;  // CALC cycles elapsed for the current operation
`endif

  // Handshake flags are decoded from registered state only. This keeps every
  // input-to-output path broken by a flop.
  assign o_in_ready  = (state == S_IDLE);
  assign o_busy      = (state == S_CALC);
  assign o_out_valid = (state == S_DONE);

  // NOTE: sequential state uses non-blocking (<=) assignments only. Every
  // register then samples the pre-edge values of the others, regardless of
  // statement order inside the block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      k        <= '0;
      o_c      <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt      <= '0;
      o_cycles <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_in_valid) begin
            x     <= i_a;
            y     <= i_b;
            k     <= '0;
`ifdef GCD_CYCLE_COUNT_EN
            cnt   <= '0;
`endif
            state <= S_CALC;
          end
        end

        S_CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
          cnt <= cnt + 1'b1;
`endif
          if (x == '0 || y == '0) begin
            // The surviving operand is the odd part of the gcd. Re-apply the
            // common factor of two. This cannot overflow: result <= max(a,b).
            o_c      <= (x | y) << k;
`ifdef GCD_CYCLE_COUNT_EN
            o_cycles <= cnt + 1'b1;
`endif
            state    <= S_DONE;
          end else if (!x[0] && !y[0]) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + 1'b1;
          end else if (!x[0]) begin
            x <= x >> 1;
          end else if (!y[0]) begin
            y <= y >> 1;
          end else if (x >= y) begin
            // The difference of two odd numbers is even, so the shift loses
            // nothing. The comparison guard rules out underflow.
            x <= (x - y) >> 1;
          end else begin
            y <= (y - x) >> 1;
          end
        end

        S_DONE: begin
          if (i_out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_binary_unit.sv
// -----------------------------------------------------------------------------
// tb_gcd_binary_unit
//
// Directed and throttled-random bench for gcd_binary_unit at WIDTH=16.
// Expected results come from hand-computed constants and a Euclid reference.
// -----------------------------------------------------------------------------
module tb_gcd_binary_unit;

  localparam int WIDTH = 16;
  localparam int N_MAX = 2 * WIDTH + 1;
  localparam int CNT_W = $clog2(2 * WIDTH + 2);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycles;
`endif

  int errors = 0;
  int checks = 0;

  gcd_binary_unit #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a         (a),
    .i_b         (b),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_c         (c),
`ifdef GCD_CYCLE_COUNT_EN
    .o_cycles    (cycles),
`endif
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] euclid(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] u, v, t;
    u = p;
    v = q;
    while (v != 0) begin
      t = u % v;
      u = v;
      v = t;
    end
    return u;
  endfunction

  // Drives one operation from a negedge in IDLE. It returns the result, the
  // number of CALC cycles seen (busy high), and the negedges from the drive
  // until out_valid. It leaves the unit in DONE when pop is 0.
  task automatic run_op(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                        input bit pop, output logic [WIDTH-1:0] res,
                        output int n, output int lat, output bit timeout);
    n       = 0;
    lat     = 0;
    timeout = 0;
    a        = opa;
    b        = opb;
    in_valid = 1'b1;
    @(negedge clk);
    lat++;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    while (!out_valid && lat < 200) begin
      if (busy) n++;
      @(negedge clk);
      lat++;
    end
    timeout = !out_valid;
    res     = c;
    if (pop && !timeout) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || c !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b c=%0d, want 1 0 0 0",
               in_ready, out_valid, busy, c);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (cycles !== '0) begin
      errors++;
      $display("FAIL reset_cycles: got %0d want 0", cycles);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 48,18: (24,9,k1) (12,9) (6,9) (3,9) (3,3) (0,3) term -> 3<<1 = 6, N=7
  task automatic test_basic;
    logic [WIDTH-1:0] res;
    int n, lat;
    bit to;
    run_op(16'd48, 16'd18, 1'b0, res, n, lat, to);
    checks++;
    if (to || res !== 16'd6) begin
      errors++;
      $display("FAIL basic_48_18: got %0d (timeout=%0d) want 6", res, to);
    end
    checks++;
    if (n != 7 || lat != 8) begin
      errors++;
      $display("FAIL basic_latency: calc=%0d valid_after=%0d want 7 and 8", n, lat);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (cycles !== CNT_W'(7)) begin
      errors++;
      $display("FAIL basic_cycles: got %0d want 7", cycles);
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 16'd6) begin
      errors++;
      $display("FAIL basic_transfer: in_ready=%b out_valid=%b c=%0d want 1 0 6",
               in_ready, out_valid, c);
    end
  endtask

  task automatic test_zero;
    logic [WIDTH-1:0] va [3] = '{16'd0, 16'd25, 16'd0};
    logic [WIDTH-1:0] vb [3] = '{16'd25, 16'd0, 16'd0};
    logic [WIDTH-1:0] ve [3] = '{16'd25, 16'd25, 16'd0};
    logic [WIDTH-1:0] res;
    int n, lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b1, res, n, lat, to);
      checks++;
      if (to || res !== ve[i] || n != 1) begin
        errors++;
        $display("FAIL zero_%0d_%0d: got %0d N=%0d want %0d N=1",
                 va[i], vb[i], res, n, ve[i]);
      end
    end
  endtask

  task automatic test_boundary;
    logic [WIDTH-1:0] va [3] = '{16'd65535, 16'd32768, 16'd65521};
    logic [WIDTH-1:0] vb [3] = '{16'd65535, 16'd49152, 16'd65519};
    logic [WIDTH-1:0] ve [3] = '{16'd65535, 16'd16384, 16'd1};
    logic [WIDTH-1:0] res;
    int n, lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b1, res, n, lat, to);
      checks++;
      if (to || res !== ve[i] || n < 1 || n > N_MAX) begin
        errors++;
        $display("FAIL boundary_%0d_%0d: got %0d N=%0d want %0d N<=%0d",
                 va[i], vb[i], res, n, ve[i], N_MAX);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [WIDTH-1:0] res;
    int n, lat;
    bit to;
    run_op(16'd65535, 16'd65535, 1'b0, res, n, lat, to);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || c !== 16'd65535) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b in_ready=%b c=%0d want 1 0 65535",
                 i, out_valid, in_ready, c);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_inputs;
    int guard;
    a        = 16'd48;
    b        = 16'd18;
    in_valid = 1'b1;
    @(negedge clk);
    // Keep offering different operands while the unit computes.
    a     = 16'd100;
    b     = 16'd75;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    // Hold in_valid through DONE as well: it must not retrigger anything.
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || c !== 16'd6) begin
      errors++;
      $display("FAIL ignore_inputs: out_valid=%b c=%0d want 1 6", out_valid, c);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc;
    logic [WIDTH-1:0] res;
    int n, lat;
    bit to;
    a        = 16'd65521;
    b        = 16'd65519;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_calc_busy: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || c !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b out_valid=%b in_ready=%b c=%0d want 0 0 1 0",
               busy, out_valid, in_ready, c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd12, 16'd8, 1'b1, res, n, lat, to);
    checks++;
    if (to || res !== 16'd4) begin
      errors++;
      $display("FAIL after_reset: got %0d want 4", res);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ra, rb, exp_c, res, held;
    int n, lat;
    bit to;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 17 == 0) ra = 0;
      if (i % 23 == 0) rb = rb & 16'hff00;
      exp_c = euclid(ra, rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, 1'b0, res, n, lat, to);
      held = c;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (c !== held || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL random_hold_%0d: c=%0d out_valid=%b want %0d 1", i, c, out_valid, held);
        end
      end
      checks++;
      if (to || res !== exp_c || n < 1 || n > N_MAX) begin
        errors++;
        $display("FAIL random_%0d gcd(%0d,%0d): got %0d N=%0d want %0d N<=%0d",
                 i, ra, rb, res, n, exp_c, N_MAX);
      end
`ifdef GCD_CYCLE_COUNT_EN
      checks++;
      if (cycles !== CNT_W'(n)) begin
        errors++;
        $display("FAIL random_cycles_%0d: got %0d want %0d", i, cycles, n);
      end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL random_handshake_%0d: in_ready=%b out_valid=%b want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_boundary();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
